// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared definitions for the EX-stage forwarding / load-use hazard unit.
//   - SEL_RF      : forwarding select value meaning "use the register file"
//   - RD_MAX_W    : storage width of a tracked destination register address.
//                   Narrower register addresses are zero-extended into it,
//                   so REG_AW must not exceed this value.
//   - trk_entry_t : one in-flight write tracked after EX {v, rd, ld}
//   - clog2       : ceiling log2, used to size the select outputs
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

  localparam int SEL_RF   = 0;
  localparam int RD_MAX_W = 8;

  // One tracked in-flight write: valid, destination register, is-a-load.
  typedef struct packed {
    logic                v;
    logic [RD_MAX_W-1:0] rd;
    logic                ld;
  } trk_entry_t;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(8) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int x = n - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match_prio.sv
// ---------------------------------------------------------------------------
// fwd_match_prio
//   Combinational priority matcher over the tracked in-flight writes.
//   Finds the youngest (lowest-index) valid entry whose destination equals
//   the operand, and reports whether that entry's value may be forwarded.
//   Register 0 never matches.
//
//   Ports:
//     entries  in   DEPTH tracker entries, index 1 = nearest stage
//     operand  in   source register address (zero-extended to RD_MAX_W)
//     hit      out  some valid entry writes the operand
//     k        out  index of the youngest matching entry (0 when no hit)
//     ready    out  youngest match can be forwarded: not a load, or the
//                   load has already passed stage LOAD_LAT
// ---------------------------------------------------------------------------
module fwd_match_prio
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  trk_entry_t [DEPTH:1]  entries,
  input  logic [RD_MAX_W-1:0]   operand,
  output logic                  hit,
  output logic [SEL_W-1:0]      k,
  output logic                  ready
);

  logic [DEPTH:1] match;
  logic [DEPTH:1] avail;

  generate
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_cmp
      // Entries beyond LOAD_LAT hold results that are ready even for loads.
      localparam bit PAST_LOAD_LAT = (gi > LOAD_LAT);

      assign match[gi] = entries[gi].v
                      && (entries[gi].rd == operand)
                      && (operand != '0);
      assign avail[gi] = !entries[gi].ld || PAST_LOAD_LAT;
    end
  endgenerate

  // Scan from oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    hit   = 1'b0;
    k     = '0;
    ready = 1'b0;
    for (int i = DEPTH; i >= 1; i--) begin
      if (match[i]) begin
        hit   = 1'b1;
        k     = SEL_W'(i);
        ready = avail[i];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   EX-stage forwarding and ID-stage load-use hazard detection.
//   In-flight register writes are tracked internally in a DEPTH-deep shift
//   register fed from the EX stage, so no downstream destination ports are
//   needed. Forwarding selects and the stall are combinational on the
//   current tracker contents and inputs.
//
//   Ports:
//     clk, rst        clock; asynchronous active-high reset
//     ex_valid        instruction in EX is live
//     ex_regwrite     EX instruction writes ex_rd
//     ex_memread      EX instruction is a load
//     ex_rd           EX destination register
//     ex_rs, ex_rt    EX source registers (A, B)
//     id_rs, id_rt    ID source registers (A, B)
//     id_uses_rt      ID instruction actually reads id_rt
//     flush           squash ID and EX this cycle
//     ctrl_rs/ctrl_rt operand mux selects: 0 = register file,
//                     k = tracker stage k (1 = nearest)
//     stall           hold PC and IF/ID, bubble into ID/EX
//     stall_count     saturating count of stalled cycles
//     fwd_err         sticky: an operand hit a load that was not yet ready
// ---------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter  int REG_AW   = 5,
  parameter  int DEPTH    = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              flush,
  output logic [SEL_W-1:0]  ctrl_rs,
  output logic [SEL_W-1:0]  ctrl_rt,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic              fwd_err
);

  // -------------------------------------------------------------------------
  // Register addresses widened to the tracker storage width
  // -------------------------------------------------------------------------
  logic [RD_MAX_W-1:0] ex_rd_w;
  logic [RD_MAX_W-1:0] ex_rs_w;
  logic [RD_MAX_W-1:0] ex_rt_w;
  logic [RD_MAX_W-1:0] id_rs_w;
  logic [RD_MAX_W-1:0] id_rt_w;

  assign ex_rd_w = RD_MAX_W'(ex_rd);
  assign ex_rs_w = RD_MAX_W'(ex_rs);
  assign ex_rt_w = RD_MAX_W'(ex_rt);
  assign id_rs_w = RD_MAX_W'(id_rs);
  assign id_rt_w = RD_MAX_W'(id_rt);

  // -------------------------------------------------------------------------
  // In-flight write tracker
  //   Entry 1 receives the EX instruction every cycle; older entries shift
  //   down and the last one falls off. The tracker keeps moving during a
  //   stall because the EX instruction always advances (the stall only
  //   holds ID and earlier). A flushed EX instruction, a non-writing one,
  //   or a write to r0 enters as an invalid bubble.
  // -------------------------------------------------------------------------
  trk_entry_t [DEPTH:1] trk_reg;
  trk_entry_t           push_entry;

  always_comb begin
    push_entry    = '0;
    push_entry.v  = ex_valid & ex_regwrite & ~flush & (ex_rd != '0);
    push_entry.rd = ex_rd_w;
    push_entry.ld = ex_memread;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_reg <= '0;
    end else begin
      trk_reg[1] <= push_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        trk_reg[k] <= trk_reg[k-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand forwarding
  // -------------------------------------------------------------------------
  logic             rs_hit;
  logic             rs_ready;
  logic [SEL_W-1:0] rs_k;
  logic             rt_hit;
  logic             rt_ready;
  logic [SEL_W-1:0] rt_k;

  fwd_match_prio #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_rs (
    .entries (trk_reg),
    .operand (ex_rs_w),
    .hit     (rs_hit),
    .k       (rs_k),
    .ready   (rs_ready)
  );

  fwd_match_prio #(
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_rt (
    .entries (trk_reg),
    .operand (ex_rt_w),
    .hit     (rt_hit),
    .k       (rt_k),
    .ready   (rt_ready)
  );

  // A youngest match that is still an unready load must not be bypassed by
  // an older entry: the operand falls back to the register file and the
  // error flag records that the pipeline failed to insert enough bubbles.
  assign ctrl_rs = (!rst && rs_hit && rs_ready) ? rs_k : SEL_W'(SEL_RF);
  assign ctrl_rt = (!rst && rt_hit && rt_ready) ? rt_k : SEL_W'(SEL_RF);

  // -------------------------------------------------------------------------
  // Load-use stall
  //   Position 0 is the live EX instruction; positions 1..DEPTH are the
  //   tracker entries. A load at position p is still unavailable to the ID
  //   instruction when p + 1 <= LOAD_LAT. Positions that can never hazard
  //   are tied off so they build no comparators.
  // -------------------------------------------------------------------------
  logic [DEPTH:0] hazard;

  generate
    for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_haz
      if (gi + 1 <= LOAD_LAT) begin : g_early
        logic                ld_live;
        logic [RD_MAX_W-1:0] ld_rd;
        logic                rs_dep;
        logic                rt_dep;

        if (gi == 0) begin : g_ex
          assign ld_live = ex_valid & ex_regwrite & ex_memread & (ex_rd != '0);
          assign ld_rd   = ex_rd_w;
        end else begin : g_trk
          assign ld_live = trk_reg[gi].v & trk_reg[gi].ld;
          assign ld_rd   = trk_reg[gi].rd;
        end

        assign rs_dep      = (ld_rd == id_rs_w) && (id_rs_w != '0);
        assign rt_dep      = id_uses_rt && (ld_rd == id_rt_w) && (id_rt_w != '0);
        assign hazard[gi]  = ld_live && (rs_dep || rt_dep);
      end else begin : g_late
        assign hazard[gi] = 1'b0;
      end
    end
  endgenerate

  // Flush squashes the dependent ID instruction, so it overrides a hazard.
  assign stall = (|hazard) & ~flush & ~rst;

  // -------------------------------------------------------------------------
  // Stall counter (saturating) and sticky forwarding-error flag
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;
  logic             err_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (stall && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign err_next = err_reg | (rs_hit & ~rs_ready) | (rt_hit & ~rt_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign stall_count = cnt_reg;
  assign fwd_err     = err_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Two instances share one stimulus stream:
//     dut_a : DEPTH=2, LOAD_LAT=1, CNT_W=4
//     dut_b : DEPTH=3, LOAD_LAT=2, CNT_W=4
//   Expected values come from a history-of-writes model: "the write issued
//   k cycles ago" is looked up directly, and a load issued p cycles ago is
//   unusable by ID while p < LOAD_LAT.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int D_A = 2;
  localparam int L_A = 1;
  localparam int D_B = 3;
  localparam int L_B = 2;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_regwrite, ex_memread;
  logic [4:0] ex_rd, ex_rs, ex_rt, id_rs, id_rt;
  logic       id_uses_rt, flush;

  logic [1:0] ctrl_rs_a, ctrl_rt_a, ctrl_rs_b, ctrl_rt_b;
  logic       stall_a, stall_b, err_a, err_b;
  logic [3:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .DEPTH(D_A), .LOAD_LAT(L_A), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .flush(flush),
    .ctrl_rs(ctrl_rs_a), .ctrl_rt(ctrl_rt_a), .stall(stall_a),
    .stall_count(cnt_a), .fwd_err(err_a)
  );

  fwd_hazard_unit #(.REG_AW(5), .DEPTH(D_B), .LOAD_LAT(L_B), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .flush(flush),
    .ctrl_rs(ctrl_rs_b), .ctrl_rt(ctrl_rt_b), .stall(stall_b),
    .stall_count(cnt_b), .fwd_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: write issued 'age' cycles ago (age 1..7).
  bit       hv  [1:7];
  bit [4:0] hrd [1:7];
  bit       hld [1:7];
  bit       err_m [2];
  int       cnt_m [2];

  function automatic void m_clear();
    for (int a = 1; a <= 7; a++) begin
      hv[a] = 0; hrd[a] = '0; hld[a] = 0;
    end
    err_m[0] = 0; err_m[1] = 0;
    cnt_m[0] = 0; cnt_m[1] = 0;
  endfunction

  // Age of the youngest visible write to x (0 = none).
  function automatic int m_age(input int d, input logic [4:0] x);
    if (x == 0) return 0;
    for (int a = 1; a <= d; a++)
      if (hv[a] && hrd[a] == x) return a;
    return 0;
  endfunction

  function automatic bit m_ready(input int a, input int ll);
    return !hld[a] || a > ll;
  endfunction

  function automatic int m_sel(input int d, input int ll, input logic [4:0] x);
    int a;
    a = m_age(d, x);
    if (a == 0 || rst) return 0;
    return m_ready(a, ll) ? a : 0;
  endfunction

  function automatic bit m_bad(input int d, input int ll, input logic [4:0] x);
    int a;
    a = m_age(d, x);
    return (a != 0) && !m_ready(a, ll);
  endfunction

  function automatic bit m_stall(input int ll);
    bit       is_ld;
    bit [4:0] r;
    if (rst || flush) return 0;
    for (int a = 0; a < ll; a++) begin
      if (a == 0) begin
        is_ld = ex_valid && ex_regwrite && ex_memread && ex_rd != 0;
        r     = ex_rd;
      end else begin
        is_ld = hv[a] && hld[a];
        r     = hrd[a];
      end
      if (is_ld && ((r == id_rs && id_rs != 0) ||
                    (id_uses_rt && r == id_rt && id_rt != 0)))
        return 1;
    end
    return 0;
  endfunction

  function automatic void m_edge(input int i, input int d, input int ll);
    if (m_bad(d, ll, ex_rs) || m_bad(d, ll, ex_rt)) err_m[i] = 1;
    if (m_stall(ll) && cnt_m[i] < CMAX) cnt_m[i]++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drv(input bit v, input bit rw, input bit mr, input logic [4:0] rd,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] irs,
                     input logic [4:0] irt, input bit u, input bit fl);
    ex_valid = v; ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
    ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt; id_uses_rt = u; flush = fl;
  endtask

  // Compare every output of both instances against the model.
  task automatic settle();
    @(negedge clk);
    chk("a.ctrl_rs", 32'(ctrl_rs_a), m_sel(D_A, L_A, ex_rs));
    chk("a.ctrl_rt", 32'(ctrl_rt_a), m_sel(D_A, L_A, ex_rt));
    chk("a.stall",   32'(stall_a),   32'(m_stall(L_A)));
    chk("a.count",   32'(cnt_a),     cnt_m[0]);
    chk("a.err",     32'(err_a),     32'(err_m[0]));
    chk("b.ctrl_rs", 32'(ctrl_rs_b), m_sel(D_B, L_B, ex_rs));
    chk("b.ctrl_rt", 32'(ctrl_rt_b), m_sel(D_B, L_B, ex_rt));
    chk("b.stall",   32'(stall_b),   32'(m_stall(L_B)));
    chk("b.count",   32'(cnt_b),     cnt_m[1]);
    chk("b.err",     32'(err_b),     32'(err_m[1]));
    $display("cyc %0d ex v%0b w%0b m%0b rd%0d rs%0d rt%0d id %0d/%0d u%0b fl%0b | a %0d/%0d st%0b c%0d e%0b | b %0d/%0d st%0b c%0d e%0b",
             cyc, ex_valid, ex_regwrite, ex_memread, ex_rd, ex_rs, ex_rt, id_rs, id_rt,
             id_uses_rt, flush, ctrl_rs_a, ctrl_rt_a, stall_a, cnt_a, err_a,
             ctrl_rs_b, ctrl_rt_b, stall_b, cnt_b, err_b);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_edge(0, D_A, L_A);
      m_edge(1, D_B, L_B);
      for (int a = 7; a >= 2; a--) begin
        hv[a] = hv[a-1]; hrd[a] = hrd[a-1]; hld[a] = hld[a-1];
      end
      hv[1]  = ex_valid && ex_regwrite && !flush && ex_rd != 0;
      hrd[1] = ex_rd;
      hld[1] = ex_memread;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  // Asynchronous reset, asserted away from any clock edge.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst.a.stall", 32'(stall_a), 0);
    chk("rst.b.stall", 32'(stall_b), 0);
    chk("rst.a.ctrl_rs", 32'(ctrl_rs_a), 0);
    chk("rst.b.ctrl_rt", 32'(ctrl_rt_b), 0);
    chk("rst.a.count", 32'(cnt_a), 0);
    chk("rst.b.count", 32'(cnt_b), 0);
    chk("rst.a.err", 32'(err_a), 0);
    chk("rst.b.err", 32'(err_b), 0);
    m_clear();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_clear();
    settle();
    chk("reset.a.ctrl_rs", 32'(ctrl_rs_a), 0);
    chk("reset.a.stall", 32'(stall_a), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1: producer r5, then forwarded from stage 1, then stage 2
    drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 5, 0, 0, 0, 0, 0); settle();
    chk("t1.a.ctrl_rs", 32'(ctrl_rs_a), 1);
    chk("t1.a.ctrl_rt", 32'(ctrl_rt_a), 0);
    tick();
    drv(1, 0, 0, 0, 0, 5, 0, 0, 0, 0); settle();
    chk("t1.a.ctrl_rt2", 32'(ctrl_rt_a), 2);
    tick();

    // 2: youngest wins; r0 never forwarded
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); step();
    drv(1, 1, 0, 7, 0, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 7, 0, 0, 0, 0, 0); settle();
    chk("t2.a.youngest", 32'(ctrl_rs_a), 1);
    tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("t2.a.r0", 32'(ctrl_rs_a), 0);
    tick();

    // 3: load-use on rs, bubble, consumer
    drv(1, 1, 1, 8, 0, 0, 8, 0, 0, 0); settle();
    chk("t3.a.stall", 32'(stall_a), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 8, 0, 0, 0); settle();
    chk("t3.a.stall_end", 32'(stall_a), 0);
    chk("t3.a.count", 32'(cnt_a), 1);
    tick();
    drv(1, 0, 0, 0, 8, 0, 0, 0, 0, 0); settle();
    chk("t3.a.ctrl_rs", 32'(ctrl_rs_a), 2);
    chk("t3.a.err", 32'(err_a), 0);
    tick();
    // rt match without id_uses_rt: no stall
    drv(1, 1, 1, 8, 0, 0, 0, 8, 0, 0); settle();
    chk("t3.a.no_rt_stall", 32'(stall_a), 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // 4: flush overrides stall and suppresses the push
    drv(1, 1, 1, 8, 0, 0, 8, 0, 0, 1); settle();
    chk("t4.a.stall", 32'(stall_a), 0);
    chk("t4.b.stall", 32'(stall_b), 0);
    tick();
    drv(1, 0, 0, 0, 8, 0, 0, 0, 0, 0); settle();
    chk("t4.a.ctrl_rs", 32'(ctrl_rs_a), 0);
    tick();

    // 5: DEPTH=3 / LOAD_LAT=2 instance
    async_reset();
    drv(1, 1, 1, 9, 0, 0, 9, 0, 0, 0); settle();
    chk("t5.b.stall0", 32'(stall_b), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    chk("t5.b.stall1", 32'(stall_b), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    chk("t5.b.stall2", 32'(stall_b), 0);
    chk("t5.b.count", 32'(cnt_b), 2);
    tick();
    drv(1, 0, 0, 0, 9, 0, 0, 0, 0, 0); settle();
    chk("t5.b.ctrl_rs", 32'(ctrl_rs_b), 3);
    chk("t5.b.err0", 32'(err_b), 0);
    tick();
    drv(1, 1, 1, 9, 0, 0, 0, 0, 0, 0); step();
    drv(1, 0, 0, 0, 9, 0, 0, 0, 0, 0); settle();
    chk("t5.b.unready", 32'(ctrl_rs_b), 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("t5.b.err_set", 32'(err_b), 1);
    tick();
    for (int i = 0; i < 3; i++) step();
    settle();
    chk("t5.b.err_sticky", 32'(err_b), 1);
    tick();

    // 6: reset mid-stall, then saturation
    drv(1, 1, 0, 9, 0, 0, 0, 0, 0, 0); step();
    drv(1, 1, 1, 8, 0, 0, 8, 0, 0, 0); settle();
    chk("t6.a.stall_pre", 32'(stall_a), 1);
    async_reset();
    drv(1, 0, 0, 0, 9, 0, 0, 0, 0, 0); settle();
    chk("t6.a.ctrl_after_rst", 32'(ctrl_rs_a), 0);
    chk("t6.b.ctrl_after_rst", 32'(ctrl_rs_b), 0);
    tick();
    for (int i = 0; i < 21; i++) begin
      drv(1, 1, 1, 8, 0, 0, 8, 0, 0, 0);
      step();
    end
    settle();
    chk("t6.a.saturate", 32'(cnt_a), CMAX);
    chk("t6.b.saturate", 32'(cnt_b), CMAX);
    tick();

    // Randomized traffic over a small register set to provoke matches.
    async_reset();
    for (int i = 0; i < 300; i++) begin
      drv(bit'($urandom_range(0, 9) < 8), bit'($urandom_range(0, 9) < 7),
          bit'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 9) == 0));
      step();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-source EX-stage forwarding unit.
- Tracks in-flight register writes internally in a DEPTH-stage shift register instead of taking EX/MEM and MEM/WB destinations as ports.
- Generates per-operand forwarding selects for the EX stage, plus a load-use stall for the ID stage.
- Sits beside the ID/EX pipeline register; adds a saturating stall performance counter and a sticky forwarding-error flag.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 2, tracked stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); legal range 1..7.
- LOAD_LAT, 1, stage index a load result must pass before it can be forwarded; legal range 0..DEPTH-1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  instruction in EX is live.
- ex_regwrite  in  1  EX instruction writes rd.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination.
- ex_rs  in  REG_AW  EX source A.
- ex_rt  in  REG_AW  EX source B.
- id_rs  in  REG_AW  ID source A.
- id_rt  in  REG_AW  ID source B.
- id_uses_rt  in  1  ID instruction reads rt.
- flush  in  1  squash ID and EX this cycle.
- ctrl_rs  out  SEL_W  source A mux select; SEL_W = clog2(DEPTH+1).
- ctrl_rt  out  SEL_W  source B mux select.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_count  out  CNT_W  stalled cycles.
- fwd_err  out  1  sticky: operand matched a not-yet-ready load.

Behaviour:
- Select encoding: 0 = register file; k = tracker stage k (1 = nearest).
- Tracker state: entries 1..DEPTH, each holding {v, rd, ld}.
  - Every clock, entry k+1 takes entry k.
  - Entry 1 takes {ex_valid & ex_regwrite & ~flush & (ex_rd != 0), ex_rd, ex_memread}.
  - The last entry falls off.
- Reset (async): all entries v = 0; stall_count = 0; fwd_err = 0. Outputs ctrl_rs = 0, ctrl_rt = 0, stall = 0 while rst is high.
- Forwarding is combinational over the current tracker entries, zero latency:
  - Operand X (rs or rt) matches entry k if v_k and rd_k == X and X != 0.
  - The lowest matching k (youngest) wins.
  - Entry k is ready if ~ld_k or k > LOAD_LAT.
  - If the youngest match is ready: ctrl = k. Else: ctrl = 0 and fwd_err is set on the next edge.
  - Register 0 always gives ctrl = 0.
- Load-use stall is combinational:
  - Position 0 is the live EX instruction (ex_valid & ex_regwrite & ex_memread & ex_rd != 0). Positions 1..DEPTH are tracker entries with ld = 1.
  - A load at position p hazards if p + 1 <= LOAD_LAT and its rd equals id_rs (nonzero), or equals id_rt (nonzero) with id_uses_rt.
  - stall = any hazard & ~flush & ~rst.
  - With LOAD_LAT = 1, only position 0 hazards, so stall is exactly one cycle.
  - In general stall lasts LOAD_LAT minus the producer's current position; the external pipeline inserts bubbles (ex_valid = 0).
- stall_count increments on each clock with stall = 1 and saturates at all-ones.
- fwd_err stays set until rst.
- Simultaneous events:
  - flush and stall together: flush wins, stall = 0, no push.
  - Reset mid-stall: stall drops immediately (async) and the tracker is empty.
- The tracker does not freeze on stall; the EX instruction always advances.

Decomposition:
- Shared package holds: select encoding constants (SEL_RF = 0), the tracker entry struct {v, rd, ld}, and a clog2 function.
- Natural sub-module: fwd_match_prio, a combinational priority matcher. It takes an entry vector plus an operand and returns {hit, k, ready}. It is instantiated once for rs and once for rt.

Test Plan:
1. DEPTH=2, LOAD_LAT=1. Cycle t: ex_rd=5, ex_regwrite=1. Cycle t+1: ex_rs=5 -> ctrl_rs=1, ctrl_rt=0. Cycle t+2: ex_rt=5 -> ctrl_rt=2.
2. Writes to r7 in consecutive cycles; then ex_rs=7 -> ctrl_rs=1 (youngest wins). ex_rd=0 with regwrite, then ex_rs=0 -> ctrl_rs=0.
3. Load-use: ex_memread=1, ex_rd=8, id_rs=8 -> stall=1 for exactly one cycle and stall_count=1. Bubble follows; consumer in EX with ex_rs=8 -> ctrl_rs=2, fwd_err=0. Repeat with id_rt=8, id_uses_rt=0 -> no stall.
4. Same load-use plus flush=1 -> stall=0. Next cycle ex_rs=8 -> ctrl_rs=0 (push suppressed).
5. DEPTH=3, LOAD_LAT=2: load r9, id_rs=9 -> stall for 2 consecutive cycles; consumer then gets ctrl_rs=3. Force consumer with no bubble (ex_rs=9 one cycle after load) -> ctrl_rs=0, fwd_err=1 and sticky.
6. Assert rst asynchronously mid-stall -> stall=0 at once; stall_count=0, fwd_err=0. After release, ex_rs matching an earlier rd -> ctrl_rs=0. Run 2^CNT_W+5 stall cycles (CNT_W=4) -> stall_count holds at 15.
